game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
- REQ-001 SHALL have parameter LIVES_INIT, default 3: lives loaded at game start (range 1..3).
- REQ-002 SHALL have parameter MAX_LEVEL, default 31: highest level value (≤31).
- REQ-003 SHALL have parameter HIT_HOLD, default 25_000_000: cycles frozen after a collision (1 s at 25 MHz).
- REQ-004 SHALL have parameter LVL_HOLD, default 12_500_000: cycles frozen after reaching the top row.
- REQ-005 SHALL have port i_Clk, input, 1 bit: the single system clock; all logic on its rising edge.
- REQ-006 SHALL have port i_Rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-007 SHALL have port i_Start, input, 1 bit: debounced start request, level-sensitive, acted on at its rising edge.
- REQ-008 SHALL have port i_Collision, input, 1 bit: frog/car overlap flag, acted on at its rising edge.
- REQ-009 SHALL have port i_Frog_At_Top, input, 1 bit: frog on goal row, acted on at its rising edge.
- REQ-010 SHALL have port i_Pause, input, 1 bit: pause toggle request, acted on at its rising edge (see Configuration).
- REQ-011 SHALL have port o_Level, output, 5 bits: current level, 0-based.
- REQ-012 SHALL have port o_Lives, output, 2 bits: remaining lives.
- REQ-013 SHALL have port o_Reset_Frog, output, 1 bit: one-cycle pulse that returns the frog to its start cell.
- REQ-014 SHALL have port o_Cars_Run, output, 1 bit: car movement enable; cars freeze when low.
- REQ-015 SHALL have port o_Game_Over, output, 1 bit: high while in GAME_OVER.
- REQ-016 SHALL have port o_State, output, 3 bits: state encoding, for debug and display.

Function
- REQ-017 SHALL edge-detect i_Start, i_Collision, i_Frog_At_Top and i_Pause with one registered previous-value flop each; an event is current=1 and previous=0.
- REQ-018 SHALL implement states IDLE=0, PLAY=1, HIT=2, LEVEL_UP=3, GAME_OVER=4, PAUSE=5; unused codes SHALL go to IDLE.
- REQ-019 IDLE: on a start event, load lives=LIVES_INIT and level=0, pulse o_Reset_Frog, and go to PLAY on the next cycle.
- REQ-020 PLAY: o_Cars_Run=1; ignore start events.
- REQ-021 PLAY, collision event with lives>1: decrement lives, load the hold counter with HIT_HOLD-1, and go to HIT.
- REQ-022 PLAY, collision event with lives==1: set lives=0 and go to GAME_OVER.
- REQ-023 PLAY, top event: increment level, saturating at MAX_LEVEL; load the hold counter with LVL_HOLD-1; go to LEVEL_UP.
- REQ-024 When a collision event and a top event occur in the same cycle, the collision SHALL win and the top event SHALL be discarded.
- REQ-025 HIT and LEVEL_UP: o_Cars_Run=0; all events ignored; the counter decrements each cycle; at 0, pulse o_Reset_Frog for exactly 1 cycle and return to PLAY.
- REQ-026 GAME_OVER: o_Cars_Run=0, o_Game_Over=1; a start event behaves exactly as in IDLE.
- REQ-027 The hold counter SHALL be $clog2(max(HIT_HOLD,LVL_HOLD)) bits wide and SHALL never underflow.
- REQ-028 All outputs SHALL be registered; event-to-output latency is 1 cycle.

Reset
- REQ-029 While i_Rst_n=0: state=IDLE, o_Level=0, o_Lives=LIVES_INIT, o_Reset_Frog=0, o_Cars_Run=0, o_Game_Over=0, hold counter=0, edge flops=0.
- REQ-030 Asserting reset mid-hold or mid-pause SHALL abort immediately; after release, the first input high SHALL count as an edge.

Configuration
- REQ-031 Macro GAME_SEQ_PAUSE_EN defined: a pause event in PLAY goes to PAUSE (o_Cars_Run=0; collision and top events ignored); a pause event in PAUSE returns to PLAY with lives and level unchanged.
- REQ-032 Macro GAME_SEQ_PAUSE_EN undefined: i_Pause is ignored, its edge flop is not built, and PAUSE is unreachable.

Structure
- REQ-033 The shared package lanes_pkg SHALL hold the state encodings, the LEVEL_W=5 and LIVES_W=2 constants, and the default hold values.
- REQ-034 A sub-module hold_timer (load, decrement, done flag) SHALL be used for both freeze intervals; there are no other sub-modules.

Verification
- REQ-035 Reset, then start pulse → o_Reset_Frog high for 1 cycle, then PLAY, o_Lives=3, o_Level=0, o_Cars_Run=1.
- REQ-036 HIT_HOLD=4, collision in PLAY → o_Lives=2, o_Cars_Run=0 for 4 cycles, o_Reset_Frog pulse, back to PLAY.
- REQ-037 Three collisions → o_Lives=0, o_Game_Over=1; a further collision causes no change; start → lives=3, level=0.
- REQ-038 Collision and top on the same cycle at level 4 → HIT, level stays 4; top events at level 31 → level stays 31.
- REQ-039 Held-high i_Collision across the return to PLAY → no second hit until it drops and rises again.
- REQ-040 With GAME_SEQ_PAUSE_EN: pause, then collision, then pause → PAUSE, no life lost, PLAY resumes; without it, pause → no state change.

Source files
------------

// File: rtl/lanes_pkg.sv
// lanes_pkg -- shared definitions for the game sequencer.
//   - state_e        : sequencer state encodings (also shown on o_State)
//   - LEVEL_W/LIVES_W: widths of the level and lives counters
//   - *_HOLD_DEFAULT : default freeze intervals in clock cycles (25 MHz)
//   - hold_width()   : width of a counter able to hold max(a,b)-1
package lanes_pkg;

    localparam int LEVEL_W = 5;
    localparam int LIVES_W = 2;

    localparam int HIT_HOLD_DEFAULT = 25_000_000;
    localparam int LVL_HOLD_DEFAULT = 12_500_000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_PAUSE     = 3'd5
    } state_e;

    // Never returns 0 so a degenerate 1-cycle hold still yields a legal vector.
    function automatic int hold_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/game_sequencer_hold_timer.sv
// hold_timer -- loadable down-counter used for both freeze intervals.
// Ports:
//   i_Clk, i_Rst_n : clock, asynchronous active-low reset (count clears to 0)
//   i_Load         : load i_Load_Val (takes priority over i_Dec)
//   i_Dec          : decrement by one; stops at zero
//   o_Done         : count is zero
module hold_timer #(
    parameter int CNT_W = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Load,
    input  logic [CNT_W-1:0] i_Load_Val,
    input  logic             i_Dec,
    output logic             o_Done
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (i_Load) begin
            cnt_d = i_Load_Val;
        end else if (i_Dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Done = (cnt_q == '0);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer -- top-level game flow controller for the frog/lanes game.
// Tracks lives and level, freezes cars after a hit or a level-up, and pulses
// a frog reset when play (re)starts.
// Ports:
//   i_Clk, i_Rst_n   : clock, asynchronous active-low reset
//   i_Start          : start request (rising edge starts a game from IDLE/GAME_OVER)
//   i_Collision      : frog/car overlap (rising edge costs a life in PLAY)
//   i_Frog_At_Top    : frog on goal row (rising edge advances level in PLAY)
//   i_Pause          : pause toggle (only with GAME_SEQ_PAUSE_EN defined)
//   o_Level, o_Lives : current level (0-based) and remaining lives
//   o_Reset_Frog     : one-cycle pulse returning the frog to its start cell
//   o_Cars_Run       : car movement enable
//   o_Game_Over      : high while in GAME_OVER
//   o_State          : current state encoding
// Build option: define GAME_SEQ_PAUSE_EN to enable the PAUSE state.
module game_sequencer
    import lanes_pkg::*;
#(
    parameter int LIVES_INIT = 3,
    parameter int MAX_LEVEL  = 31,
    parameter int HIT_HOLD   = HIT_HOLD_DEFAULT,
    parameter int LVL_HOLD   = LVL_HOLD_DEFAULT
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Start,
    input  logic               i_Collision,
    input  logic               i_Frog_At_Top,
    input  logic               i_Pause,
    output logic [LEVEL_W-1:0] o_Level,
    output logic [LIVES_W-1:0] o_Lives,
    output logic               o_Reset_Frog,
    output logic               o_Cars_Run,
    output logic               o_Game_Over,
    output logic [2:0]         o_State
);

    localparam int               CNT_W       = hold_width(HIT_HOLD, LVL_HOLD);
    localparam logic [CNT_W-1:0] HIT_LOAD    = CNT_W'(HIT_HOLD - 1);
    localparam logic [CNT_W-1:0] LVL_LOAD    = CNT_W'(LVL_HOLD - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(MAX_LEVEL);
    localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(LIVES_INIT);

    state_e             state_d, state_q;
    logic [LIVES_W-1:0] lives_d, lives_q;
    logic [LEVEL_W-1:0] level_d, level_q;
    logic               reset_frog_d, reset_frog_q;
    logic               cars_run_d, cars_run_q;
    logic               game_over_d, game_over_q;

    logic               timer_load;
    logic [CNT_W-1:0]   timer_load_val;
    logic               timer_dec;
    logic               timer_done;

    // Previous-value flops: an event is a 0->1 transition seen on a clock edge.
    logic start_prev_q, coll_prev_q, top_prev_q;
    logic start_ev, coll_ev, top_ev;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            start_prev_q <= 1'b0;
            coll_prev_q  <= 1'b0;
            top_prev_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            start_prev_q <= i_Start;
            coll_prev_q  <= i_Collision;
            top_prev_q   <= i_Frog_At_Top;
        end
    end

    assign start_ev = i_Start       & ~start_prev_q;
    assign coll_ev  = i_Collision   & ~coll_prev_q;
    assign top_ev   = i_Frog_At_Top & ~top_prev_q;

`ifdef GAME_SEQ_PAUSE_EN
    logic pause_prev_q;
    logic pause_ev;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            pause_prev_q <= 1'b0;
        end else begin
            pause_prev_q <= i_Pause;
        end
    end

    assign pause_ev = i_Pause & ~pause_prev_q;
`else
    logic unused_pause;
    assign unused_pause = i_Pause;
`endif

    hold_timer #(
        .CNT_W(CNT_W)
    ) u_hold_timer (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .i_Load     (timer_load),
        .i_Load_Val (timer_load_val),
        .i_Dec      (timer_dec),
        .o_Done     (timer_done)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d        = state_q;
        lives_d        = lives_q;
        level_d        = level_q;
        reset_frog_d   = 1'b0;
        timer_load     = 1'b0;
        timer_load_val = '0;
        timer_dec      = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_ev) begin
                    state_d      = ST_PLAY;
                    lives_d      = LIVES_START;
                    level_d      = '0;
                    reset_frog_d = 1'b1;
                end
            end
            ST_PLAY: begin
                // Collision is checked first so a simultaneous top event is dropped.
                if (coll_ev) begin
                    if (lives_q > LIVES_W'(1)) begin
                        lives_d        = lives_q - LIVES_W'(1);
                        timer_load     = 1'b1;
                        timer_load_val = HIT_LOAD;
                        state_d        = ST_HIT;
                    end else begin
                        lives_d = '0;
                        state_d = ST_GAME_OVER;
                    end
                end else if (top_ev) begin
                    if (level_q < LEVEL_TOP) begin
                        level_d = level_q + LEVEL_W'(1);
                    end
                    timer_load     = 1'b1;
                    timer_load_val = LVL_LOAD;
                    state_d        = ST_LEVEL_UP;
                end
`ifdef GAME_SEQ_PAUSE_EN
                else if (pause_ev) begin
                    state_d = ST_PAUSE;
                end
`endif
            end
            ST_HIT, ST_LEVEL_UP: begin
                if (timer_done) begin
                    state_d      = ST_PLAY;
                    reset_frog_d = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
            end
`ifdef GAME_SEQ_PAUSE_EN
            ST_PAUSE: begin
                if (pause_ev) begin
                    state_d = ST_PLAY;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Outputs are derived from the next state so they register alongside it.
        cars_run_d  = (state_d == ST_PLAY);
        game_over_d = (state_d == ST_GAME_OVER);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= ST_IDLE;
            lives_q      <= LIVES_START;
            level_q      <= '0;
            reset_frog_q <= 1'b0;
            cars_run_q   <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            reset_frog_q <= reset_frog_d;
            cars_run_q   <= cars_run_d;
            game_over_q  <= game_over_d;
        end
    end

    assign o_Level      = level_q;
    assign o_Lives      = lives_q;
    assign o_Reset_Frog = reset_frog_q;
    assign o_Cars_Run   = cars_run_q;
    assign o_Game_Over  = game_over_q;
    assign o_State      = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer -- directed self-checking bench for game_sequencer.
// Runs with HIT_HOLD=4 and LVL_HOLD=3 so freeze intervals are short; the
// pause section follows whichever GAME_SEQ_PAUSE_EN build is compiled.
module tb_game_sequencer;

    localparam logic [31:0] S_IDLE = 0, S_PLAY = 1, S_HIT = 2, S_LVL = 3, S_OVER = 4, S_PAUSE = 5;

    logic       i_Clk = 1'b0;
    logic       i_Rst_n = 1'b0;
    logic       i_Start = 1'b0;
    logic       i_Collision = 1'b0;
    logic       i_Frog_At_Top = 1'b0;
    logic       i_Pause = 1'b0;
    logic [4:0] o_Level;
    logic [1:0] o_Lives;
    logic       o_Reset_Frog;
    logic       o_Cars_Run;
    logic       o_Game_Over;
    logic [2:0] o_State;

    int checks = 0;
    int failures = 0;

    always #5 i_Clk = ~i_Clk;

    game_sequencer #(
        .LIVES_INIT (3),
        .MAX_LEVEL  (31),
        .HIT_HOLD   (4),
        .LVL_HOLD   (3)
    ) dut (
        .i_Clk         (i_Clk),
        .i_Rst_n       (i_Rst_n),
        .i_Start       (i_Start),
        .i_Collision   (i_Collision),
        .i_Frog_At_Top (i_Frog_At_Top),
        .i_Pause       (i_Pause),
        .o_Level       (o_Level),
        .o_Lives       (o_Lives),
        .o_Reset_Frog  (o_Reset_Frog),
        .o_Cars_Run    (o_Cars_Run),
        .o_Game_Over   (o_Game_Over),
        .o_State       (o_State)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    // Bounded wait for a state; an expired budget shows up as a failed check.
    task automatic wait_state(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 20 && {29'd0, o_State} !== exp; i++) tick();
        check(tag, {29'd0, o_State}, exp);
    endtask

    task automatic do_top();
        i_Frog_At_Top = 1'b1;
        tick();
        i_Frog_At_Top = 1'b0;
        check("lvl_state", {29'd0, o_State}, S_LVL);
        check("lvl_cars",  {31'd0, o_Cars_Run}, 0);
        wait_state("lvl_return", S_PLAY);
    endtask

    initial begin
        // Reset values
        tick(2);
        check("rst_state", {29'd0, o_State}, S_IDLE);
        check("rst_level", {27'd0, o_Level}, 0);
        check("rst_lives", {30'd0, o_Lives}, 3);
        check("rst_frog",  {31'd0, o_Reset_Frog}, 0);
        check("rst_cars",  {31'd0, o_Cars_Run}, 0);
        check("rst_over",  {31'd0, o_Game_Over}, 0);
        i_Rst_n = 1'b1;
        tick();

        // Start: frog reset pulse together with entry to PLAY, lasting one cycle
        i_Start = 1'b1;
        tick();
        check("start_frog",  {31'd0, o_Reset_Frog}, 1);
        check("start_state", {29'd0, o_State}, S_PLAY);
        i_Start = 1'b0;
        tick();
        check("start_frog_end", {31'd0, o_Reset_Frog}, 0);
        check("start_lives", {30'd0, o_Lives}, 3);
        check("start_level", {27'd0, o_Level}, 0);
        check("start_cars",  {31'd0, o_Cars_Run}, 1);

        // Start event ignored in PLAY
        i_Start = 1'b1;
        tick();
        check("play_start_state", {29'd0, o_State}, S_PLAY);
        check("play_start_frog",  {31'd0, o_Reset_Frog}, 0);
        i_Start = 1'b0;

        // First collision: cars frozen for exactly HIT_HOLD=4 cycles
        i_Collision = 1'b1;
        tick();
        i_Collision = 1'b0;
        check("hit1_state", {29'd0, o_State}, S_HIT);
        check("hit1_lives", {30'd0, o_Lives}, 2);
        check("hit1_cars0", {31'd0, o_Cars_Run}, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("hit1_cars_hold", {31'd0, o_Cars_Run}, 0);
            check("hit1_state_hold", {29'd0, o_State}, S_HIT);
        end
        tick();
        check("hit1_ret_state", {29'd0, o_State}, S_PLAY);
        check("hit1_ret_frog",  {31'd0, o_Reset_Frog}, 1);
        check("hit1_ret_cars",  {31'd0, o_Cars_Run}, 1);
        tick();
        check("hit1_frog_end",  {31'd0, o_Reset_Frog}, 0);

        // Second collision held high across the return to PLAY: no re-trigger
        i_Collision = 1'b1;
        tick();
        check("hit2_lives", {30'd0, o_Lives}, 1);
        wait_state("hit2_return", S_PLAY);
        tick(3);
        check("held_state", {29'd0, o_State}, S_PLAY);
        check("held_lives", {30'd0, o_Lives}, 1);

        // Third collision (new edge) with one life left: game over
        i_Collision = 1'b0;
        tick();
        i_Collision = 1'b1;
        tick();
        check("over_state", {29'd0, o_State}, S_OVER);
        check("over_lives", {30'd0, o_Lives}, 0);
        check("over_flag",  {31'd0, o_Game_Over}, 1);
        check("over_cars",  {31'd0, o_Cars_Run}, 0);

        // Further collision in GAME_OVER changes nothing
        i_Collision = 1'b0;
        tick();
        i_Collision = 1'b1;
        tick();
        i_Collision = 1'b0;
        check("over_coll_state", {29'd0, o_State}, S_OVER);
        check("over_coll_lives", {30'd0, o_Lives}, 0);

        // Restart from GAME_OVER
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        check("restart_state", {29'd0, o_State}, S_PLAY);
        check("restart_lives", {30'd0, o_Lives}, 3);
        check("restart_level", {27'd0, o_Level}, 0);
        check("restart_frog",  {31'd0, o_Reset_Frog}, 1);
        check("restart_over",  {31'd0, o_Game_Over}, 0);
        tick();

        // Four level-ups to reach level 4
        for (int i = 0; i < 4; i++) do_top();
        check("level4", {27'd0, o_Level}, 4);

        // Collision and top together: collision wins
        i_Collision = 1'b1;
        i_Frog_At_Top = 1'b1;
        tick();
        i_Collision = 1'b0;
        i_Frog_At_Top = 1'b0;
        check("both_state", {29'd0, o_State}, S_HIT);
        check("both_level", {27'd0, o_Level}, 4);
        check("both_lives", {30'd0, o_Lives}, 2);
        wait_state("both_return", S_PLAY);
        check("both_level_after", {27'd0, o_Level}, 4);

        // Climb to the top level, then confirm saturation
        for (int i = 0; i < 27; i++) do_top();
        check("level31", {27'd0, o_Level}, 31);
        do_top();
        check("level31_sat", {27'd0, o_Level}, 31);
        do_top();
        check("level31_sat2", {27'd0, o_Level}, 31);

`ifdef GAME_SEQ_PAUSE_EN
        // Pause, collision ignored while paused, resume
        i_Pause = 1'b1;
        tick();
        i_Pause = 1'b0;
        check("pause_state", {29'd0, o_State}, S_PAUSE);
        check("pause_cars",  {31'd0, o_Cars_Run}, 0);
        i_Collision = 1'b1;
        tick();
        i_Collision = 1'b0;
        check("pause_coll_state", {29'd0, o_State}, S_PAUSE);
        check("pause_coll_lives", {30'd0, o_Lives}, 2);
        tick();
        i_Pause = 1'b1;
        tick();
        i_Pause = 1'b0;
        check("resume_state", {29'd0, o_State}, S_PLAY);
        check("resume_lives", {30'd0, o_Lives}, 2);
        check("resume_level", {27'd0, o_Level}, 31);
        check("resume_cars",  {31'd0, o_Cars_Run}, 1);
`else
        // Pause disabled: request has no effect
        i_Pause = 1'b1;
        tick();
        i_Pause = 1'b0;
        tick();
        check("nopause_state", {29'd0, o_State}, S_PLAY);
        check("nopause_cars",  {31'd0, o_Cars_Run}, 1);
        check("nopause_lives", {30'd0, o_Lives}, 2);
`endif

        // Reset mid-hold aborts immediately; a start held through reset counts as an edge
        i_Collision = 1'b1;
        tick();
        i_Collision = 1'b0;
        check("prereset_state", {29'd0, o_State}, S_HIT);
        #2;
        i_Rst_n = 1'b0;
        i_Start = 1'b1;
        #1;
        check("midhold_rst_state", {29'd0, o_State}, S_IDLE);
        check("midhold_rst_lives", {30'd0, o_Lives}, 3);
        check("midhold_rst_level", {27'd0, o_Level}, 0);
        check("midhold_rst_cars",  {31'd0, o_Cars_Run}, 0);
        tick();
        i_Rst_n = 1'b1;
        tick();
        check("post_rst_start", {29'd0, o_State}, S_PLAY);
        check("post_rst_frog",  {31'd0, o_Reset_Frog}, 1);
        i_Start = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
